inst_rom_arbiter: RTL and testbench
===================================

// Module: inst_rom_arbiter
// PURPOSE
//   Shares the single combinational instruction ROM between two requesters:
//   port 0 = IF-stage fetch, port 1 = auxiliary reader (debug/loader).
//   Grants at most one request per cycle, drives ROM ce/addr, registers the ROM word and
//   returns it with a one-cycle ack. Sits between pc_reg/if_id and inst_rom; stall0 feeds ctrl.
// PARAMETERS
//   ADDR_W    32  address width (matches InstAddrBus)
//   DATA_W    32  instruction width (matches InstBus)
//   LOCK_MAX  4   max consecutive grants to port 1 while lock1 is held (1..15)
// PORTS
//   clk       in   1       single clock, rising edge
//   rst       in   1       asynchronous, active-low reset (asserted when 0)
//   req0      in   1       port 0 request; addr0 must be stable while req0=1 and not granted
//   addr0     in   ADDR_W  port 0 byte address
//   ack0      out  1       port 0 response valid (one-cycle pulse)
//   rdata0    out  DATA_W  port 0 instruction, valid when ack0=1
//   stall0    out  1       req0=1 and port 0 not granted this cycle (to ctrl)
//   req1      in   1       port 1 request
//   addr1     in   ADDR_W  port 1 byte address
//   lock1     in   1       port 1 requests back-to-back grants (burst)
//   ack1      out  1       port 1 response valid (one-cycle pulse)
//   rdata1    out  DATA_W  port 1 instruction, valid when ack1=1
//   rom_ce    out  1       ROM chip enable (ChipEnable when a grant is issued)
//   rom_addr  out  ADDR_W  address of granted port; ZeroWord when no grant
//   rom_inst  in   DATA_W  combinational ROM data for rom_addr
// BEHAVIOUR
//   - Reset: ack0=ack1=0, rdata0=rdata1=ZeroWord, last_gnt=1 (port 0 wins first tie),
//     lock_cnt=0, state=ARB. stall0, rom_ce, rom_addr are combinational (0 / ZeroWord when idle).
//   - Grant is combinational in cycle N; rom_ce=1, rom_addr=addr of granted port.
//   - Cycle N+1: ackX=1, rdataX=rom_inst sampled at edge N; other port's ack=0.
//     Latency exactly 1 cycle; one grant per cycle; back-to-back grants allowed.
//   - rdataX holds its last value when ackX=0.
//   - Request is accepted at grant: dropping reqX in N+1 does not cancel ackX.
//   - FSM states: ARB, LOCK1.
//     ARB: both req -> arbitration policy (see CONFIGURATION); single req -> granted.
//       If port 1 granted with lock1=1 -> LOCK1, lock_cnt=1.
//     LOCK1: port 1 granted each cycle while req1&lock1 and lock_cnt<LOCK_MAX, lock_cnt++.
//       Exit to ARB (lock_cnt=0) when req1=0, lock1=0, or lock_cnt==LOCK_MAX;
//       on that exit cycle normal ARB policy applies in the same cycle, with port 0 preferred
//       if req0=1 (bounds port-0 starvation to LOCK_MAX cycles).
//   - last_gnt updates only on cycles with a grant.
//   - No request: rom_ce=ChipDisable, no state change.
//   - Address bits: arbiter passes full byte address; word indexing is done by the ROM.
//   - rst asserted mid-transaction: pending ack dropped, no ack after release.
// CONFIGURATION
//   ROM_ARB_RR_EN defined: on contention in ARB, round-robin -- grant the port not in
//     last_gnt; last_gnt toggles with each contended grant.
//   ROM_ARB_RR_EN undefined: fixed priority, port 0 always wins in ARB;
//     last_gnt still tracked but unused; LOCK1 behaviour unchanged.
// TESTING
//   1 reset: rst=0 with req0=req1=1 -> ack0=ack1=0, rdata=0, rom_ce=0; release -> port 0 granted first.
//   2 single fetch: req0=1, addr0=0x8, ROM word2=0x34011100 -> next cycle ack0=1,
//     rdata0=0x34011100; stall0=0 throughout.
//   3 contention, RR_EN defined: req0=req1=1 for 4 cycles ->
//     grants 0,1,0,1; stall0=1 on cycles 2,4.
//   4 same stimulus, RR_EN undefined -> grants 0,0,0,0; ack1 never asserted; stall0=0.
//   5 lock burst LOCK_MAX=4: req1=lock1=1, req0=1 -> 4 port-1 grants, then port 0
//     granted on 5th cycle; stall0=1 for exactly 4 cycles.
//   6 mid-op reset: grant port 1, assert rst in N+1 before edge -> ack1 stays 0, rdata1=0.

Source files
------------

// File: rtl/inst_rom_arbiter_if.sv
// Requester and ROM-side signal bundle for inst_rom_arbiter.
// The arbiter takes the slave modport; the requesters and the ROM take the master modport.
interface inst_rom_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              stall0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              lock1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport slave (
        input  req0, addr0, req1, addr1, lock1, rom_inst,
        output ack0, rdata0, stall0, ack1, rdata1, rom_ce, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, lock1, rom_inst,
        input  ack0, rdata0, stall0, ack1, rdata1, rom_ce, rom_addr
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of the combinational instruction ROM (port 0 = fetch, port 1 = aux).
// Define ROM_ARB_RR_EN for round-robin on contention; default build is fixed priority to port 0.
module inst_rom_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    inst_rom_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]   lock_cnt_nxt;
    logic               last_gnt;
    logic               last_gnt_nxt;
    logic               gnt0;
    logic               gnt1;
    logic               use_arb;

    // Arbitration state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            lock_cnt <= '0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Grant decision; a LOCK1 exit falls back to ARB policy in the same cycle with port 0 first
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        last_gnt_nxt = last_gnt;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        use_arb      = 1'b0;

        if (rst) begin
            case (state)
                ARB: begin
                    use_arb = 1'b1;
                end
                LOCK1: begin
                    if (bus.req1 && bus.lock1 && (lock_cnt < CNT_W'(LOCK_MAX))) begin
                        gnt1         = 1'b1;
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end else begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                        if (bus.req0) begin
                            gnt0 = 1'b1;
                        end else begin
                            use_arb = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end
            endcase

            if (use_arb) begin
                if (bus.req0 && bus.req1) begin
`ifdef ROM_ARB_RR_EN
                    if (last_gnt) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
`else
                    gnt0 = 1'b1;
`endif
                end else if (bus.req0) begin
                    gnt0 = 1'b1;
                end else if (bus.req1) begin
                    gnt1 = 1'b1;
                end

                if (gnt1 && bus.lock1) begin
                    state_nxt    = LOCK1;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end

            if (gnt0 || gnt1) begin
                last_gnt_nxt = gnt1;
            end
        end
    end

    // Registered responses; rdata holds between acks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            bus.ack0 <= gnt0;
            bus.ack1 <= gnt1;
            if (gnt0) begin
                bus.rdata0 <= bus.rom_inst;
            end
            if (gnt1) begin
                bus.rdata1 <= bus.rom_inst;
            end
        end
    end

    assign bus.rom_ce   = gnt0 | gnt1;
    assign bus.rom_addr = gnt1 ? bus.addr1 : (gnt0 ? bus.addr0 : '0);
    assign bus.stall0   = rst & bus.req0 & ~gnt0;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboard bench for inst_rom_arbiter: stimulus queues expected acks, a monitor pops and checks them.
// Expectations follow ROM_ARB_RR_EN when it is defined for the build.
module tb_inst_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned cyc_cnt = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t q[$];
    exp_t me;

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:2] == 30'd2) return 32'h3401_1100;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Combinational ROM model
    always_comb bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // One cycle of stimulus; g = expected granted port (2 = none), st = expected stall0
    task automatic step(input logic r0, input logic [31:0] a0, input logic r1,
                        input logic [31:0] a1, input logic l1, input int g, input logic st);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req0 = r0; bus.addr0 = a0;
        bus.req1 = r1; bus.addr1 = a1; bus.lock1 = l1;
        @(negedge clk);
        check("stall0", 32'(bus.stall0), 32'(st));
        check("rom_ce", 32'(bus.rom_ce), (g == 2) ? 32'd0 : 32'd1);
        check("rom_addr", bus.rom_addr, (g == 0) ? a0 : ((g == 1) ? a1 : 32'h0));
        if (g != 2) begin
            e.port = (g == 1);
            e.data = rom_word((g == 1) ? a1 : a0);
            e.due  = cyc_cnt + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2, 1'b0);
    endtask

    // Monitor: every ack must match the oldest queued expectation due this cycle
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc_cnt) begin
            me = q.pop_front();
            check("ack_pair", {30'h0, bus.ack1, bus.ack0}, me.port ? 32'd2 : 32'd1);
            check(me.port ? "rdata1" : "rdata0", me.port ? bus.rdata1 : bus.rdata0, me.data);
        end else if (bus.ack0 || bus.ack1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)",
                     bus.ack0, bus.ack1, cyc_cnt);
        end
    end

    initial begin
        bus.req0 = 1'b1; bus.addr0 = 32'h100;
        bus.req1 = 1'b1; bus.addr1 = 32'h200; bus.lock1 = 1'b0;

        // Reset held with both requests pending
        repeat (2) @(negedge clk);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_rdata0", bus.rdata0, 32'h0);
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_rom_ce", 32'(bus.rom_ce), 32'd0);

        // Release: port 0 wins the first tie
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_rom_addr", bus.rom_addr, 32'h100);
        check("rel_stall0", 32'(bus.stall0), 32'd0);
        q.push_back('{port: 1'b0, data: rom_word(32'h100), due: cyc_cnt + 1});

        // Single fetch of word 2 and rdata hold
        step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        idle();
        idle();
        check("rdata0_hold", bus.rdata0, 32'h3401_1100);

        // Port 1 single read leaves last_gnt = 1
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1, 1'b0);

        // Four cycles of contention
        for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARB_RR_EN
            step(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, i % 2, 1'(i % 2));
`else
            step(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 0, 1'b0);
`endif
        end
        idle();

        // Lock burst: four port-1 grants, then port 0 on the exit cycle
`ifdef ROM_ARB_RR_EN
        step(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h24, 1'b1, 32'h90 + 32'(4 * i), 1'b1, 1, 1'b1);
`else
        step(1'b0, 32'h0, 1'b1, 32'h90, 1'b1, 1, 1'b0);
        for (int i = 1; i < 4; i++)
            step(1'b1, 32'h24, 1'b1, 32'h90 + 32'(4 * i), 1'b1, 1, 1'b1);
`endif
        step(1'b1, 32'h24, 1'b1, 32'hA0, 1'b1, 0, 1'b0);
        idle();

        // Early lock exit on lock1 drop, port 0 preferred
        step(1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, 1, 1'b0);
        step(1'b1, 32'h28, 1'b1, 32'hC4, 1'b0, 0, 1'b0);
        idle();
        idle();

        // Reset between grant and the capturing edge drops the ack
        @(posedge clk);
        #1;
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.addr1 = 32'h44; bus.lock1 = 1'b0;
        @(negedge clk);
        check("pre_rst_rom_ce", 32'(bus.rom_ce), 32'd1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ack1", 32'(bus.ack1), 32'd0);
        check("midrst_rdata1", bus.rdata1, 32'h0);
        check("midrst_rdata0", bus.rdata0, 32'h0);
        bus.req1 = 1'b0;
        rst = 1'b1;
        idle();
        idle();
        check("post_rst_ack1", 32'(bus.ack1), 32'd0);

        idle();
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
